smc_access_seq26: RTL and testbench
===================================

SMC_ACCESS_SEQ26 -- requirements
Module: smc_access_seq26

Interface
REQ-001 SHALL have parameter WS_W, default 4: width of the wait-state configuration fields.
REQ-002 SHALL have ports:
- hclk26, input, 1: AHB system clock; all state changes on rising edge.
- n_sys_reset26, input, 1: asynchronous, active-low reset.
- new_access26, input, 1: one-cycle strobe in the AHB address phase.
- n_read26, input, 1: 1 = write, 0 = read; sampled with new_access26.
- xfer_size26, input, 2: 00 byte, 01 half, 10 word; sampled with new_access26.
- addr, input, 32: access address; sampled with new_access26.
- write_data26, input, 32: AHB write data; sampled in the SETUP cycle (AHB data phase).
- cfg_mem_width, input, 2: external bus width, 00 = 8, 01 = 16, 10/11 = 32 bits.
- cfg_wait_rd, input, WS_W: extra read strobe cycles.
- cfg_wait_wr, input, WS_W: extra write strobe cycles.
- cfg_turn, input, 2: idle cycles between beats.
- smc_data_in, input, 32: external read data; the narrow-memory lanes are LSB-aligned.
- smc_idle26, output, 1: sequencer in IDLE.
- smc_done26, output, 1: last cycle of the current beat.
- mac_done26, output, 1: the current beat is the final beat.
- read_data26, output, 32: assembled read data.
- smc_addr, output, 32: external address.
- smc_data_out, output, 32: external write data.
- smc_n_cs, output, 1: chip select, active low.
- smc_n_oe, output, 1: output enable, active low.
- smc_n_we, output, 1: write enable, active low.
- smc_n_be, output, 4: byte enables, active low.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, SETUP, STROBE, TURN.
REQ-004 IDLE: on new_access26 = 1, SHALL capture n_read26, xfer_size26, addr, all cfg_* inputs and the beat count, and go to SETUP next cycle.
REQ-005 SHALL ignore new_access26 outside IDLE; captured configuration SHALL be immune to cfg_* changes mid-access.
REQ-006 Beat count:
- bytes = 1 << size;
- mem_bytes = 1, 2 or 4 from cfg_mem_width;
- beats = max(1, bytes / mem_bytes), giving 1, 2 or 4.
REQ-007 SETUP (1 cycle):
- smc_n_cs = 0, smc_addr valid, strobes deasserted;
- for writes, capture write_data26 into an internal register;
- go to STROBE and load the wait counter with cfg_wait_rd or cfg_wait_wr.
REQ-008 STROBE:
- smc_n_oe = 0 for reads, smc_n_we = 0 for writes;
- the counter decrements to 0, so STROBE lasts wait+1 cycles;
- smc_done26 = 1 in the cycle the counter is 0.
REQ-009 At the end of a beat:
- if more beats remain, go to TURN when cfg_turn > 0, else directly to SETUP;
- otherwise go to TURN when cfg_turn > 0, else to IDLE.
REQ-010 TURN:
- all strobes and smc_n_cs = 1 for cfg_turn cycles;
- then go to SETUP if beats remain, else to IDLE.
REQ-011 mac_done26 SHALL be 1 throughout SETUP and STROBE of the final beat, else 0; smc_done26 & mac_done26 marks access completion.
REQ-012 smc_addr for beat k SHALL be the captured addr + k*mem_bytes (32-bit wrap-around, no carry out).
REQ-013 smc_n_be:
- 32-bit memory: lanes selected by addr[1:0] and size;
- narrower memory: only the LSB mem_bytes lanes low.
REQ-014 smc_data_out for beat k SHALL be the captured write data >> (8*k*mem_bytes); with one beat, the byte/half data SHALL stay on the AHB lane.
REQ-015 Reads: beat k data SHALL be stored into read_data26 lanes [8*k*mem_bytes +: 8*mem_bytes] at the smc_done26 cycle.
REQ-016 In the final smc_done26 cycle, the final-beat lanes of read_data26 SHALL be driven combinationally from smc_data_in, so data is valid with completion.
REQ-017 With one beat on a 32-bit memory, read_data26 SHALL equal smc_data_in during smc_done26.
REQ-018 smc_idle26 SHALL be 1 only in IDLE; a new_access26 in the IDLE cycle after completion SHALL be accepted.

Reset
REQ-019 SHALL reset asynchronously on n_sys_reset26 = 0 to IDLE with:
- smc_idle26 = 1;
- smc_done26 = 0, mac_done26 = 0;
- smc_n_cs/oe/we = 1, smc_n_be = 4'hF;
- smc_addr, smc_data_out, read_data26 = 0;
- counters = 0.
REQ-020 Reset mid-access SHALL deassert all strobes immediately and discard the access; no smc_done26 SHALL follow.

Structure
REQ-021 State encoding, memory-width codes and size codes SHALL live in shared package smc_seq_pkg26.
REQ-022 The wait/turn down-counter SHALL be sub-module smc_wait_cnt26 (load, decrement, zero flag).

Verification
REQ-023 32-bit memory word read, wait_rd = 2, turn = 0, addr 0x100, data_in 0xCAFEF00D:
- SETUP 1 cycle, STROBE 3 cycles;
- smc_done26 & mac_done26 in the 4th cycle with read_data26 = 0xCAFEF00D;
- IDLE in the 5th.
REQ-024 8-bit memory word write 0x11223344 to addr 0x200, wait_wr = 0, turn = 1:
- 4 beats at 0x200..0x203 with smc_data_out[7:0] = 44, 33, 22, 11;
- TURN cycle after each beat;
- mac_done26 set only on beat 4.
REQ-025 16-bit memory word read, data_in 0xBEEF then 0xDEAD -> read_data26 = 0xDEADBEEF at final completion.
REQ-026 new_access26 pulsed during STROBE, and cfg_wait_rd changed mid-access -> both ignored; timing unchanged.
REQ-027 n_sys_reset26 asserted in beat 2 of a 4-beat read:
- strobes high asynchronously, IDLE, no smc_done26;
- next access completes normally.

Source files
------------

// File: rtl/smc_seq_pkg26.sv
// ---------------------------------------------------------------------------
// smc_seq_pkg26
// Shared definitions for the static memory access sequencer:
//   - seq_state_t : sequencer state encoding (IDLE, SETUP, STROBE, TURN)
//   - MW_*        : external memory width codes (cfg_mem_width)
//   - SZ_*        : AHB transfer size codes (xfer_size26)
//   - helpers turning size / width codes into log2 byte counts and a beat count
// ---------------------------------------------------------------------------
package smc_seq_pkg26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_TURN   = 2'd3
  } seq_state_t;

  localparam logic [1:0] MW_8  = 2'b00;
  localparam logic [1:0] MW_16 = 2'b01;
  localparam logic [1:0] MW_32 = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // log2 of the external bus width in bytes; code 11 is also a 32-bit bus
  function automatic logic [1:0] mem_log2(input logic [1:0] mw);
    if (mw == MW_8)       return 2'd0;
    else if (mw == MW_16) return 2'd1;
    else                  return 2'd2;
  endfunction

  // log2 of the transfer size in bytes; the unused code 11 is treated as a word
  function automatic logic [1:0] size_log2(input logic [1:0] sz);
    if (sz == SZ_BYTE)      return 2'd0;
    else if (sz == SZ_HALF) return 2'd1;
    else                    return 2'd2;
  endfunction

  // Number of external beats: transfer bytes / bus bytes, never below one
  function automatic logic [2:0] beat_count(input logic [1:0] sz, input logic [1:0] mw);
    logic [1:0] s;
    logic [1:0] m;
    s = size_log2(sz);
    m = mem_log2(mw);
    if (s <= m) return 3'd1;
    else        return 3'd1 << (s - m);
  endfunction

endpackage

// File: rtl/smc_wait_cnt26.sv
// ---------------------------------------------------------------------------
// smc_wait_cnt26
// Loadable down-counter timing the STROBE and TURN phases.
//   hclk26, n_sys_reset26 : clock, asynchronous active-low reset
//   load, load_val        : load a new count (has priority over dec)
//   dec                   : decrement, saturating at zero
//   zero                  : count is zero
// ---------------------------------------------------------------------------
module smc_wait_cnt26 #(
  parameter int W = 4
) (
  input  logic         hclk26,
  input  logic         n_sys_reset26,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge hclk26 or negedge n_sys_reset26) begin
    if (!n_sys_reset26)              count <= '0;
    else if (load)                   count <= load_val;
    else if (dec && (count != '0))   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/smc_access_seq26.sv
// ---------------------------------------------------------------------------
// smc_access_seq26
// Turns one AHB access into 1, 2 or 4 beats on a static memory bus of
// 8, 16 or 32 bits. Each beat is SETUP (1 cycle), STROBE (wait+1 cycles) and
// optionally TURN (cfg_turn idle cycles).
//   inputs : hclk26, n_sys_reset26, new_access26, n_read26, xfer_size26, addr,
//            write_data26, cfg_mem_width, cfg_wait_rd, cfg_wait_wr, cfg_turn,
//            smc_data_in
//   outputs: smc_idle26, smc_done26 (last beat cycle), mac_done26 (final beat),
//            read_data26, smc_addr, smc_data_out, smc_n_cs, smc_n_oe,
//            smc_n_we, smc_n_be
// ---------------------------------------------------------------------------
module smc_access_seq26
  import smc_seq_pkg26::*;
#(
  parameter int WS_W = 4
) (
  input  logic            hclk26,
  input  logic            n_sys_reset26,
  input  logic            new_access26,
  input  logic            n_read26,
  input  logic [1:0]      xfer_size26,
  input  logic [31:0]     addr,
  input  logic [31:0]     write_data26,
  input  logic [1:0]      cfg_mem_width,
  input  logic [WS_W-1:0] cfg_wait_rd,
  input  logic [WS_W-1:0] cfg_wait_wr,
  input  logic [1:0]      cfg_turn,
  input  logic [31:0]     smc_data_in,
  output logic            smc_idle26,
  output logic            smc_done26,
  output logic            mac_done26,
  output logic [31:0]     read_data26,
  output logic [31:0]     smc_addr,
  output logic [31:0]     smc_data_out,
  output logic            smc_n_cs,
  output logic            smc_n_oe,
  output logic            smc_n_we,
  output logic [3:0]      smc_n_be
);

  // The counter must hold both a wait value and cfg_turn-1
  localparam int CW = (WS_W > 2) ? WS_W : 2;

  seq_state_t state, next_state;

  logic            is_write;
  logic [1:0]      size_lg;
  logic [1:0]      mem_lg;
  logic [WS_W-1:0] wait_rd_q;
  logic [WS_W-1:0] wait_wr_q;
  logic [1:0]      turn_q;
  logic [2:0]      beats_q;
  logic [1:0]      beat_idx;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;

  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic [CW-1:0]   cnt_val;

  logic            accept;
  logic            beat_end;
  logic            last_beat;
  logic            advance;
  logic [1:0]      off_bytes;
  logic [4:0]      shift_bits;
  logic [31:0]     lane_mask;
  logic [31:0]     rd_merge;

  smc_wait_cnt26 #(.W(CW)) u_wait_cnt (
    .hclk26        (hclk26),
    .n_sys_reset26 (n_sys_reset26),
    .load          (cnt_load),
    .load_val      (cnt_val),
    .dec           (cnt_dec),
    .zero          (cnt_zero)
  );

  assign accept    = (state == ST_IDLE) && new_access26;
  assign beat_end  = (state == ST_STROBE) && cnt_zero;
  assign last_beat = ({1'b0, beat_idx} == (beats_q - 3'd1));
  // beat_idx moves on only when the next beat's SETUP starts, so TURN still
  // sees the beat that just finished when deciding between SETUP and IDLE
  assign advance   = (state != ST_IDLE) && (next_state == ST_SETUP);

  // Byte offset of the current beat from the captured address
  always_comb begin
    case (mem_lg)
      2'd0:    off_bytes = beat_idx;
      2'd1:    off_bytes = {beat_idx[0], 1'b0};
      default: off_bytes = 2'b00;
    endcase
  end

  assign shift_bits = {off_bytes, 3'b000};

  always_comb begin
    case (mem_lg)
      2'd0:    lane_mask = 32'h0000_00FF << shift_bits;
      2'd1:    lane_mask = 32'h0000_FFFF << shift_bits;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Narrow memory data arrives on the low lanes and is moved up to its slot
  assign rd_merge = (rdata_q & ~lane_mask) | ((smc_data_in << shift_bits) & lane_mask);

  always_ff @(posedge hclk26 or negedge n_sys_reset26) begin
    if (!n_sys_reset26) state <= ST_IDLE;
    else                state <= next_state;
  end

  always_ff @(posedge hclk26 or negedge n_sys_reset26) begin
    if (!n_sys_reset26) begin
      is_write  <= 1'b0;
      size_lg   <= 2'd0;
      mem_lg    <= 2'd0;
      wait_rd_q <= '0;
      wait_wr_q <= '0;
      turn_q    <= 2'd0;
      beats_q   <= 3'd1;
      beat_idx  <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      if (accept) begin
        is_write  <= n_read26;
        size_lg   <= size_log2(xfer_size26);
        mem_lg    <= mem_log2(cfg_mem_width);
        wait_rd_q <= cfg_wait_rd;
        wait_wr_q <= cfg_wait_wr;
        turn_q    <= cfg_turn;
        beats_q   <= beat_count(xfer_size26, cfg_mem_width);
        beat_idx  <= 2'd0;
        addr_q    <= addr;
        rdata_q   <= 32'd0;
      end else if (advance) begin
        beat_idx  <= beat_idx + 2'd1;
      end
      // AHB write data is only valid in the first data phase
      if ((state == ST_SETUP) && is_write && (beat_idx == 2'd0))
        wdata_q <= write_data26;
      if (beat_end && !is_write)
        rdata_q <= rd_merge;
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    smc_done26 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (new_access26) next_state = ST_SETUP;
      end
      ST_SETUP: begin
        next_state = ST_STROBE;
        cnt_load   = 1'b1;
        cnt_val    = is_write ? CW'(wait_wr_q) : CW'(wait_rd_q);
      end
      ST_STROBE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          smc_done26 = 1'b1;
          if (turn_q != 2'd0) begin
            next_state = ST_TURN;
            cnt_load   = 1'b1;
            cnt_val    = CW'(turn_q - 2'd1);
          end else begin
            next_state = last_beat ? ST_IDLE : ST_SETUP;
          end
        end
      end
      ST_TURN: begin
        if (!cnt_zero) cnt_dec = 1'b1;
        else           next_state = last_beat ? ST_IDLE : ST_SETUP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    smc_n_be = 4'hF;
    if ((state == ST_SETUP) || (state == ST_STROBE)) begin
      case (mem_lg)
        2'd0: smc_n_be = 4'b1110;
        2'd1: smc_n_be = 4'b1100;
        default: begin
          case (size_lg)
            2'd0:    smc_n_be = ~(4'b0001 << addr_q[1:0]);
            2'd1:    smc_n_be = addr_q[1] ? 4'b0011 : 4'b1100;
            default: smc_n_be = 4'b0000;
          endcase
        end
      endcase
    end
  end

  assign smc_idle26   = (state == ST_IDLE);
  assign mac_done26   = ((state == ST_SETUP) || (state == ST_STROBE)) && last_beat;
  assign smc_n_cs     = !((state == ST_SETUP) || (state == ST_STROBE));
  assign smc_n_oe     = !((state == ST_STROBE) && !is_write);
  assign smc_n_we     = !((state == ST_STROBE) && is_write);
  assign smc_addr     = addr_q + {30'd0, off_bytes};
  assign smc_data_out = wdata_q >> shift_bits;
  // Final read beat bypasses the register so data is valid with completion
  assign read_data26  = (beat_end && !is_write && last_beat) ? rd_merge : rdata_q;

endmodule

// File: tb/tb_smc_access_seq26.sv
// ---------------------------------------------------------------------------
// tb_smc_access_seq26
// Directed bench for smc_access_seq26: a table of whole accesses with
// hand-computed results, plus hand-written sequences for split read data,
// ignored mid-access inputs and reset during an access.
// ---------------------------------------------------------------------------
module tb_smc_access_seq26;

  logic        hclk26;
  logic        n_sys_reset26;
  logic        new_access26;
  logic        n_read26;
  logic [1:0]  xfer_size26;
  logic [31:0] addr;
  logic [31:0] write_data26;
  logic [1:0]  cfg_mem_width;
  logic [3:0]  cfg_wait_rd;
  logic [3:0]  cfg_wait_wr;
  logic [1:0]  cfg_turn;
  logic [31:0] smc_data_in;
  logic        smc_idle26;
  logic        smc_done26;
  logic        mac_done26;
  logic [31:0] read_data26;
  logic [31:0] smc_addr;
  logic [31:0] smc_data_out;
  logic        smc_n_cs;
  logic        smc_n_oe;
  logic        smc_n_we;
  logic [3:0]  smc_n_be;

  int n_vec = 0;
  int n_err = 0;

  smc_access_seq26 #(.WS_W(4)) dut (
    .hclk26        (hclk26),
    .n_sys_reset26 (n_sys_reset26),
    .new_access26  (new_access26),
    .n_read26      (n_read26),
    .xfer_size26   (xfer_size26),
    .addr          (addr),
    .write_data26  (write_data26),
    .cfg_mem_width (cfg_mem_width),
    .cfg_wait_rd   (cfg_wait_rd),
    .cfg_wait_wr   (cfg_wait_wr),
    .cfg_turn      (cfg_turn),
    .smc_data_in   (smc_data_in),
    .smc_idle26    (smc_idle26),
    .smc_done26    (smc_done26),
    .mac_done26    (mac_done26),
    .read_data26   (read_data26),
    .smc_addr      (smc_addr),
    .smc_data_out  (smc_data_out),
    .smc_n_cs      (smc_n_cs),
    .smc_n_oe      (smc_n_oe),
    .smc_n_we      (smc_n_we),
    .smc_n_be      (smc_n_be)
  );

  initial hclk26 = 1'b0;
  always #5 hclk26 = ~hclk26;

  typedef struct {
    logic        n_read;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mw;
    logic [3:0]  wait_c;
    logic [1:0]  turn;
    logic [31:0] din;
    int          exp_cycles;
    int          exp_beats;
    logic [3:0]  exp_be;
    logic [31:0] exp_first_addr;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_dout;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives an access request in the current (IDLE) cycle; returns at the
  // falling edge of the SETUP cycle
  task automatic startAccess(input logic nr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] mw,
                             input logic [3:0] wc, input logic [1:0] tn);
    n_read26      = nr;
    xfer_size26   = sz;
    addr          = a;
    write_data26  = wd;
    cfg_mem_width = mw;
    cfg_wait_rd   = wc;
    cfg_wait_wr   = wc;
    cfg_turn      = tn;
    new_access26  = 1'b1;
    @(negedge hclk26);
    new_access26  = 1'b0;
  endtask

  task automatic waitDone(input logic want_mac, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (smc_done26 && (mac_done26 == want_mac)) ok = 1'b1;
      else @(negedge hclk26);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int cyc, dones, mac_out;
    logic fin, first;
    logic [3:0]  be;
    logic [31:0] fa, la, ld, rd;
    v = vecs[idx];
    smc_data_in = v.din;
    startAccess(v.n_read, v.size, v.addr, v.wdata, v.mw, v.wait_c, v.turn);
    cyc = 0; dones = 0; mac_out = 0; fin = 1'b0; first = 1'b1;
    be = 4'hF; fa = '0; la = '0; ld = '0; rd = '0;
    for (int i = 0; i < 200 && !fin; i++) begin
      cyc++;
      if (!smc_n_cs && (!smc_n_oe || !smc_n_we)) begin
        if (first) begin
          be = smc_n_be;
          fa = smc_addr;
          first = 1'b0;
        end
        la = smc_addr;
        ld = smc_data_out;
      end
      if (mac_done26 && smc_n_cs) mac_out++;
      if (smc_done26) dones++;
      if (smc_done26 && mac_done26) begin
        fin = 1'b1;
        rd  = read_data26;
      end else begin
        @(negedge hclk26);
      end
    end
    checkOutput($sformatf("v%0d_completed", idx), 32'(fin), 32'd1);
    checkOutput($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
    checkOutput($sformatf("v%0d_beats", idx), dones, v.exp_beats);
    checkOutput($sformatf("v%0d_n_be", idx), 32'(be), 32'(v.exp_be));
    checkOutput($sformatf("v%0d_first_addr", idx), fa, v.exp_first_addr);
    checkOutput($sformatf("v%0d_last_addr", idx), la, v.exp_last_addr);
    checkOutput($sformatf("v%0d_mac_outside", idx), mac_out, 0);
    if (v.n_read) checkOutput($sformatf("v%0d_last_dout", idx), ld, v.exp_last_dout);
    else          checkOutput($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    @(negedge hclk26);
    for (int i = 0; i < 10 && !smc_idle26; i++) @(negedge hclk26);
    checkOutput($sformatf("v%0d_idle_after", idx), 32'(smc_idle26), 32'd1);
  endtask

  initial begin
    logic ok;
    int dcount;

    //        nr  sz     addr           wdata          mw     wt    tn     din            cyc bt be       first          last           dout           rdata
    vecs[0] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         2'd2, 4'd2, 2'd0, 32'hCAFE_F00D, 4,  1, 4'b0000, 32'h0000_0100, 32'h0000_0100, 32'h0,         32'hCAFE_F00D};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_0103, 32'hAABB_CCDD, 2'd2, 4'd1, 2'd0, 32'h0,         3,  1, 4'b0111, 32'h0000_0103, 32'h0000_0103, 32'hAABB_CCDD, 32'h0};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_0042, 32'h0,         2'd2, 4'd0, 2'd0, 32'h1234_5678, 2,  1, 4'b0011, 32'h0000_0042, 32'h0000_0042, 32'h0,         32'h1234_5678};
    vecs[3] = '{1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344, 2'd0, 4'd0, 2'd1, 32'h0,         11, 4, 4'b1110, 32'h0000_0200, 32'h0000_0203, 32'h0000_0011, 32'h0};
    vecs[4] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         2'd1, 4'd1, 2'd2, 32'h1234_BEEF, 8,  2, 4'b1100, 32'h0000_0300, 32'h0000_0302, 32'h0,         32'hBEEF_BEEF};
    vecs[5] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         2'd0, 4'd0, 2'd0, 32'hFFFF_FF5A, 4,  2, 4'b1110, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         32'h0000_5A5A};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0011, 32'h9988_7766, 2'd1, 4'd3, 2'd0, 32'h0,         5,  1, 4'b1100, 32'h0000_0011, 32'h0000_0011, 32'h9988_7766, 32'h0};
    vecs[7] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0BAD_F00D, 2'd3, 4'd0, 2'd3, 32'h0,         2,  1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 32'h0};

    n_sys_reset26 = 1'b0;
    new_access26  = 1'b0;
    n_read26      = 1'b0;
    xfer_size26   = 2'd0;
    addr          = 32'd0;
    write_data26  = 32'd0;
    cfg_mem_width = 2'd0;
    cfg_wait_rd   = 4'd0;
    cfg_wait_wr   = 4'd0;
    cfg_turn      = 2'd0;
    smc_data_in   = 32'd0;

    #1;
    checkOutput("rst_idle", 32'(smc_idle26), 32'd1);
    checkOutput("rst_done", 32'(smc_done26), 32'd0);
    checkOutput("rst_mac", 32'(mac_done26), 32'd0);
    checkOutput("rst_strobes", 32'({smc_n_cs, smc_n_oe, smc_n_we}), 32'h7);
    checkOutput("rst_n_be", 32'(smc_n_be), 32'hF);
    checkOutput("rst_addr", smc_addr, 32'd0);
    checkOutput("rst_dout", smc_data_out, 32'd0);
    checkOutput("rst_rdata", read_data26, 32'd0);

    @(negedge hclk26);
    @(negedge hclk26);
    n_sys_reset26 = 1'b1;
    @(negedge hclk26);

    // Table accesses run back to back: each new request lands in the first
    // IDLE cycle after the previous one
    for (int i = 0; i < 8; i++) applyStimulus(i);

    // 16-bit read, two beats with different data
    $display("[TB] split read on 16-bit memory");
    smc_data_in = 32'h0000_BEEF;
    startAccess(1'b0, 2'd2, 32'h0000_0400, 32'h0, 2'd1, 4'd0, 2'd0);
    waitDone(1'b0, ok);
    checkOutput("split_beat1_done", 32'(ok), 32'd1);
    @(posedge hclk26);
    #1 smc_data_in = 32'h0000_DEAD;
    @(negedge hclk26);
    waitDone(1'b1, ok);
    checkOutput("split_final_done", 32'(ok), 32'd1);
    checkOutput("split_rdata", read_data26, 32'hDEAD_BEEF);
    @(negedge hclk26);
    checkOutput("split_idle", 32'(smc_idle26), 32'd1);

    // new_access and cfg_wait_rd changes in STROBE must not disturb the access
    $display("[TB] ignored inputs during strobe");
    smc_data_in = 32'h1357_2468;
    startAccess(1'b0, 2'd2, 32'h0000_0100, 32'h0, 2'd2, 4'd2, 2'd0);
    @(negedge hclk26);
    checkOutput("ign_strobe_oe", 32'(smc_n_oe), 32'd0);
    new_access26 = 1'b1;
    cfg_wait_rd  = 4'd7;
    addr         = 32'hDEAD_0000;
    @(negedge hclk26);
    new_access26 = 1'b0;
    checkOutput("ign_cycle3_done", 32'(smc_done26), 32'd0);
    @(negedge hclk26);
    checkOutput("ign_cycle4_done", 32'({smc_done26, mac_done26}), 32'h3);
    checkOutput("ign_rdata", read_data26, 32'h1357_2468);
    checkOutput("ign_addr", smc_addr, 32'h0000_0100);
    @(negedge hclk26);
    checkOutput("ign_idle5", 32'(smc_idle26), 32'd1);
    @(negedge hclk26);
    checkOutput("ign_stays_idle", 32'({smc_idle26, smc_n_cs}), 32'h3);
    cfg_wait_rd = 4'd0;

    // Reset during beat 2 of a 4-beat read
    $display("[TB] reset mid-access");
    smc_data_in = 32'h0000_0077;
    startAccess(1'b0, 2'd2, 32'h0000_0500, 32'h0, 2'd0, 4'd1, 2'd0);
    waitDone(1'b0, ok);
    checkOutput("rstmid_beat1", 32'(ok), 32'd1);
    @(negedge hclk26);
    @(negedge hclk26);
    checkOutput("rstmid_beat2_oe", 32'(smc_n_oe), 32'd0);
    #2 n_sys_reset26 = 1'b0;
    #1;
    checkOutput("rstmid_strobes", 32'({smc_n_cs, smc_n_oe, smc_n_we}), 32'h7);
    checkOutput("rstmid_idle", 32'(smc_idle26), 32'd1);
    checkOutput("rstmid_n_be", 32'(smc_n_be), 32'hF);
    @(negedge hclk26);
    @(negedge hclk26);
    n_sys_reset26 = 1'b1;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (smc_done26 || !smc_idle26) dcount++;
      @(negedge hclk26);
    end
    checkOutput("rstmid_no_done", dcount, 0);
    applyStimulus(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
